serial_subtractor20: RTL and testbench
======================================

// Module: serial_subtractor20
// PURPOSE
//  Bit-serial 20-bit subtractor: D = A - B, one bit per clock, LSB first.
//  Uses a single full-subtractor cell and a borrow flip-flop.
//  Serves as the area-lean inverse of the 20-bit ripple adder in the
//  Step-3 arithmetic datapath.
//  Start/done handshake; the result holds until the next accepted start.
// PARAMETERS
//  WIDTH  20  operand/result width in bits; must be >= 2
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous reset, active-high
//  start       in   1      request; sampled only in IDLE or DONE
//  a           in   WIDTH  minuend, captured on the accepted start
//  b           in   WIDTH  subtrahend, captured on the accepted start
//  busy        out  1      high while in SHIFT
//  done        out  1      one-cycle pulse when d and borrow_out are valid
//  d           out  WIDTH  difference (A - B) mod 2^WIDTH
//  borrow_out  out  1      1 when A < B as unsigned values
//  ovf         out  1      signed overflow; present only with SUB_OVF_EN
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0, done=0, d=0, borrow_out=0,
//   ovf=0; operand regs, count and borrow FF cleared.
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE/DONE with start=1: load A_r=a, B_r=b, bw=0, cnt=0; go to SHIFT.
//  - IDLE with start=0: stay in IDLE.
//  - SHIFT, each cycle:
//     diff = A_r[0]^B_r[0]^bw
//     bw'  = (~A_r[0]&B_r[0]) | (~(A_r[0]^B_r[0])&bw)
//     A_r and B_r shift right by 1; diff enters the result reg at MSB
//     (shift right); cnt++.
//     When cnt==WIDTH-1: go to DONE; d takes the full result;
//     borrow_out=bw'.
//  - DONE: done=1 for exactly one cycle; d and borrow_out stay valid.
//    Then go to SHIFT if start=1, else IDLE.
//  Latency: start accepted at edge N -> done high in the cycle after
//   edge N+WIDTH. Back-to-back throughput is one op per WIDTH+1 cycles.
//  busy=1 exactly in SHIFT, for WIDTH cycles.
//  start while busy: ignored; the operation in flight is unaffected.
//  a and b are don't-care except on the accepting edge.
//  d, borrow_out and ovf update only on entry to DONE; held otherwise,
//   including through IDLE.
//  rst asserted mid-SHIFT: abort immediately, all outputs to reset
//   values, no done pulse.
//  Boundaries:
//   - A==B: d=0, borrow_out=0.
//   - 0-1: d=all ones, borrow_out=1.
//   - B=0: d=A, borrow_out=0.
// CONFIGURATION
//  SUB_OVF_EN defined: port ovf exists. On DONE entry,
//   ovf = (A[MSB]^B[MSB]) & (A[MSB]^d[MSB]), using the operand MSBs
//   captured at start. ovf is held like d.
//  SUB_OVF_EN undefined: no ovf port and no MSB capture logic;
//   all other behaviour is identical.
// TESTING
//  1. a=5, b=3, start 1 cycle -> done after 21 cycles; d=0x00002,
//     borrow_out=0.
//  2. a=3, b=5 -> d=0xFFFFE, borrow_out=1. Then a=0, b=1 -> d=0xFFFFF,
//     borrow_out=1.
//  3. a=b=0xFFFFF -> d=0, borrow_out=0. Then start held high through
//     DONE -> next op starts with no IDLE cycle.
//  4. Start 0x00010-0x00001. Pulse start with a=0, b=0 at cycle 5 of
//     SHIFT -> ignored; d=0x0000F.
//  5. Assert rst at cycle 10 of SHIFT -> busy=0, d=0, no done pulse.
//     Next op 7-7 -> d=0.
//  6. (SUB_OVF_EN) a=0x80000, b=1 -> d=0x7FFFF, ovf=1.
//     a=0x00001, b=0x00001 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor20.sv
// Bit-serial WIDTH-bit subtractor (D = A - B, LSB first) with a start/done handshake.
// Optional signed-overflow output `ovf` is enabled by defining SUB_OVF_EN.
module serial_subtractor20 #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [CNT_W-1:0]   cnt;
    logic               bw;
    logic               diff, bw_n, last, load;
`ifdef SUB_OVF_EN
    logic               a_msb, b_msb;
`endif

    always_comb begin
        diff = a_r[0] ^ b_r[0] ^ bw;
        bw_n = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & bw);
        last = (cnt == CNT_W'(WIDTH - 1));
        load = start && ((state == IDLE) || (state == DONE));
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE:  if (start) state_n = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = start ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // The difference bits are shifted into the top of a_r as the minuend
    // drains out of the bottom, so a_r doubles as the result accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            cnt        <= '0;
            bw         <= 1'b0;
            d          <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else if (load) begin
            a_r <= a;
            b_r <= b;
            cnt <= '0;
            bw  <= 1'b0;
`ifdef SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_r <= {diff, a_r[WIDTH-1:1]};
            b_r <= {1'b0, b_r[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
            bw  <= bw_n;
            if (last) begin
                d          <= {diff, a_r[WIDTH-1:1]};
                borrow_out <= bw_n;
`ifdef SUB_OVF_EN
                ovf        <= (a_msb ^ b_msb) & (a_msb ^ diff);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor20.sv
// Directed self-checking bench for serial_subtractor20 (WIDTH=20).
// Checks ovf as well when compiled with SUB_OVF_EN.
module tb_serial_subtractor20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] a, b;
    logic        busy, done, borrow_out;
    logic [19:0] d;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    int seen_done;

    serial_subtractor20 #(.WIDTH(20)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .d          (d),
        .borrow_out (borrow_out)
`ifdef SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Launch one op, check latency, result, then the single-cycle pulse and hold.
    task automatic do_op(input [19:0] av, input [19:0] bv, input [19:0] ed,
                         input logic eb, input string tag);
        int k;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 20'($urandom); b = 20'($urandom);
        check({tag, "_busy"}, busy, 1);
        wait_done(k);
        check({tag, "_latency"}, k, 20);
        check({tag, "_d"}, d, ed);
        check({tag, "_borrow"}, borrow_out, eb);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_d_held"}, d, ed);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_borrow", borrow_out, 0);
        rst = 1'b0;

        // 1, 2, B=0
        do_op(20'h00005, 20'h00003, 20'h00002, 1'b0, "t1_5m3");
        do_op(20'h00003, 20'h00005, 20'hFFFFE, 1'b1, "t2_3m5");
        do_op(20'h00000, 20'h00001, 20'hFFFFF, 1'b1, "t2_0m1");
        do_op(20'hABCDE, 20'h00000, 20'hABCDE, 1'b0, "b_zero");

        // 3: A==B, then start held through DONE for back-to-back
        @(negedge clk);
        a = 20'hFFFFF; b = 20'hFFFFF; start = 1'b1;
        @(negedge clk);
        a = 20'h12345; b = 20'h00345;
        wait_done(n);
        check("t3_latency", n, 20);
        check("t3_d", d, 20'h00000);
        check("t3_borrow", borrow_out, 0);
        @(negedge clk);
        start = 1'b0;
        check("t3_b2b_busy", busy, 1);
        check("t3_b2b_done", done, 0);
        wait_done(n);
        check("t3_b2b_latency", n, 20);
        check("t3_b2b_d", d, 20'h12000);
        check("t3_b2b_borrow", borrow_out, 0);

        // 4: start during SHIFT ignored
        @(negedge clk);
        a = 20'h00010; b = 20'h00001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = '0; b = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy", busy, 1);
        wait_done(n);
        check("t4_latency", n, 14);
        check("t4_d", d, 20'h0000F);
        check("t4_borrow", borrow_out, 0);

        // 5: reset mid-SHIFT
        @(negedge clk);
        a = 20'h00003; b = 20'h00005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_d", d, 0);
        check("t5_borrow", borrow_out, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("t5_no_done", seen_done, 0);
        check("t5_idle_busy", busy, 0);
        do_op(20'h00007, 20'h00007, 20'h00000, 1'b0, "t5_7m7");

`ifdef SUB_OVF_EN
        do_op(20'h80000, 20'h00001, 20'h7FFFF, 1'b0, "t6_ovf");
        check("t6_ovf_set", ovf, 1);
        do_op(20'h00001, 20'h00001, 20'h00000, 1'b0, "t6_noovf");
        check("t6_ovf_clr", ovf, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
